// File: rtl/inst_queue.sv
// Dual-issue instruction queue: circular buffer accepting a fetch pair and delivering up to two
// head entries per cycle. Optional same-cycle empty-queue bypass under macro INST_QUEUE_BYPASS_EN.
module inst_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 96
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [1:0]              push_valid,
    input  logic [2*DATA_W-1:0]     push_data,
    output logic                    push_ready,
    output logic [1:0]              pop_valid,
    output logic [2*DATA_W-1:0]     pop_data,
    input  logic [1:0]              pop_cnt,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(DEPTH - 2);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ready_r;

    logic [DATA_W-1:0] slot0_s, slot1_s, cmp0_s, cmp1_s, wr_lo_s;
    logic [PTR_W-1:0]  head_nx_s, tail_nx_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [1:0]        n_push_s, n_pop_s, pop_req_s, avail_s, skip_s, head_adv_s, n_wr_s;
    logic              bypass_s;

    assign slot0_s   = push_data[DATA_W-1:0];
    assign slot1_s   = push_data[2*DATA_W-1:DATA_W];
    assign head_nx_s = head_r + PTR_ONE;
    assign tail_nx_s = tail_r + PTR_ONE;

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass_s = (count_r == CNT_ZERO) && !flush;
`else
    assign bypass_s = 1'b0;
`endif

    // Accepted push count and compacted slot order (a lone slot 1 becomes the first entry)
    always_comb begin
        n_push_s = 2'd0;
        cmp0_s   = push_valid[0] ? slot0_s : slot1_s;
        cmp1_s   = slot1_s;
        if (push_ready_r && !flush) begin
            n_push_s = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};
        end else begin
            n_push_s = 2'd0;
        end
    end

    // Head view, clamped pop amount and resulting write/pointer bookkeeping
    always_comb begin
        avail_s    = 2'd0;
        pop_data   = {mem_r[head_nx_s], mem_r[head_r]};
        pop_req_s  = 2'd0;
        n_pop_s    = 2'd0;
        skip_s     = 2'd0;
        head_adv_s = 2'd0;
        n_wr_s     = 2'd0;
        wr_lo_s    = cmp0_s;
        if (bypass_s) begin
            avail_s  = n_push_s;
            pop_data = {cmp1_s, cmp0_s};
        end else if (count_r >= CNT_TWO) begin
            avail_s = 2'd2;
        end else if (count_r >= CNT_ONE) begin
            avail_s = 2'd1;
        end else begin
            avail_s = 2'd0;
        end
        case (pop_cnt)
            2'd0:    pop_req_s = 2'd0;
            2'd1:    pop_req_s = 2'd1;
            default: pop_req_s = 2'd2;
        endcase
        if (flush) begin
            n_pop_s = 2'd0;
        end else if (pop_req_s < avail_s) begin
            n_pop_s = pop_req_s;
        end else begin
            n_pop_s = avail_s;
        end
        // Bypassed entries consumed this cycle are never stored, so head stays put
        if (bypass_s) begin
            skip_s     = n_pop_s;
            head_adv_s = 2'd0;
        end else begin
            skip_s     = 2'd0;
            head_adv_s = n_pop_s;
        end
        n_wr_s  = n_push_s - skip_s;
        wr_lo_s = (skip_s == 2'd0) ? cmp0_s : cmp1_s;
    end

    assign pop_valid   = {(avail_s >= 2'd2), (avail_s >= 2'd1)};
    assign count_nxt_s = count_r + CNT_W'(n_push_s) - CNT_W'(n_pop_s);

    // Pointer, occupancy and ready registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r       <= {PTR_W{1'b0}};
            tail_r       <= {PTR_W{1'b0}};
            count_r      <= CNT_ZERO;
            push_ready_r <= 1'b1;
        end else if (flush) begin
            head_r       <= {PTR_W{1'b0}};
            tail_r       <= {PTR_W{1'b0}};
            count_r      <= CNT_ZERO;
            push_ready_r <= 1'b1;
        end else begin
            head_r       <= head_r + PTR_W'(head_adv_s);
            tail_r       <= tail_r + PTR_W'(n_wr_s);
            count_r      <= count_nxt_s;
            push_ready_r <= (count_nxt_s <= CNT_HI);
        end
    end

    // Entry storage, intentionally without reset
    always_ff @(posedge clk) begin
        if (!reset && (n_wr_s != 2'd0)) begin
            mem_r[tail_r] <= wr_lo_s;
        end
        if (!reset && (n_wr_s == 2'd2)) begin
            mem_r[tail_nx_s] <= cmp1_s;
        end
    end

    assign push_ready = push_ready_r;
    assign count      = count_r;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a scoreboard queue mirrors expected contents and is compared
// against the head ports every cycle and against occupancy after every edge.
module tb_inst_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 96;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  flush;
    logic [1:0]            push_valid;
    logic [2*DATA_W-1:0]   push_data;
    logic                  push_ready;
    logic [1:0]            pop_valid;
    logic [2*DATA_W-1:0]   pop_data;
    logic [1:0]            pop_cnt;
    logic [CNT_W-1:0]      count;

    logic [DATA_W-1:0] model_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int seq      = 1;

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_cnt    (pop_cnt),
        .count      (count)
    );

    function automatic logic [DATA_W-1:0] make_data(input int n);
        logic [31:0] v;
        v = 32'(n);
        return {v, 32'h5A5A_0000 ^ v, ~v};
    endfunction

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock of stimulus: check head ports before the edge, occupancy after it
    task automatic step(input logic [1:0] pv, input logic [1:0] pc, input logic fl);
        logic [DATA_W-1:0] d0, d1;
        logic [DATA_W-1:0] in_q [$];
        logic [DATA_W-1:0] view [$];
        int  n_take;
        bit  ready, byp;
        @(negedge clk);
        d0 = make_data(seq);
        d1 = make_data(seq + 1);
        seq += 2;
        push_valid = pv;
        push_data  = {d1, d0};
        pop_cnt    = pc;
        flush      = fl;
        ready = (DEPTH - model_q.size()) >= 2;
        in_q = {};
        if (ready && !fl) begin
            if (pv[0]) in_q.push_back(d0);
            if (pv[1]) in_q.push_back(d1);
        end
        byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        byp = (model_q.size() == 0) && !fl;
`endif
        if (byp) view = in_q;
        else     view = model_q;
        #2;
        check("pop_valid0", DATA_W'(pop_valid[0]), DATA_W'(view.size() >= 1));
        check("pop_valid1", DATA_W'(pop_valid[1]), DATA_W'(view.size() >= 2));
        if (view.size() >= 1) check("pop_data0", pop_data[DATA_W-1:0], view[0]);
        if (view.size() >= 2) check("pop_data1", pop_data[2*DATA_W-1:DATA_W], view[1]);
        check("push_ready", DATA_W'(push_ready), DATA_W'(ready));
        n_take = (pc == 2'd0) ? 0 : (pc == 2'd1) ? 1 : 2;
        if (n_take > view.size()) n_take = view.size();
        if (fl) begin
            model_q = {};
        end else if (byp) begin
            for (int i = n_take; i < in_q.size(); i++) model_q.push_back(in_q[i]);
        end else begin
            repeat (n_take) void'(model_q.pop_front());
            foreach (in_q[i]) model_q.push_back(in_q[i]);
        end
        @(posedge clk);
        #1;
        check("count", DATA_W'(count), DATA_W'(model_q.size()));
    endtask

    // Reset for one edge while a push is offered, then verify the empty state
    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b1;
        push_valid = 2'b11;
        push_data  = {make_data(900), make_data(901)};
        pop_cnt    = 2'd2;
        flush      = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        model_q = {};
        check("rst_count", DATA_W'(count), DATA_W'(0));
        check("rst_pop_valid", DATA_W'(pop_valid), DATA_W'(0));
        check("rst_push_ready", DATA_W'(push_ready), DATA_W'(1));
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        push_valid = 2'b00;
        push_data  = '0;
        pop_cnt    = 2'd0;
        repeat (2) @(posedge clk);
        apply_reset();

        // Single pair then observe it at the head
        step(2'b11, 2'd0, 1'b0);
        step(2'b00, 2'd0, 1'b0);

        // Fill to 8 and offer more pairs while full
        repeat (3) step(2'b11, 2'd0, 1'b0);
        repeat (2) step(2'b11, 2'd0, 1'b0);

        // Drain to 1, then pop_cnt=2 with only one entry alongside a pair push
        repeat (3) step(2'b00, 2'd2, 1'b0);
        step(2'b00, 2'd1, 1'b0);
        step(2'b11, 2'd2, 1'b0);

        // Streaming two in / two out across pointer wrap
        repeat (20) step(2'b11, 2'd2, 1'b0);

        // Single-slot pushes, compaction of slot 1, near-full readiness, pop_cnt=3
        step(2'b01, 2'd0, 1'b0);
        step(2'b10, 2'd0, 1'b0);
        step(2'b11, 2'd0, 1'b0);
        step(2'b01, 2'd0, 1'b0);
        step(2'b11, 2'd0, 1'b0);
        step(2'b00, 2'd3, 1'b0);

        // Flush at count 5 with simultaneous push and pop
        step(2'b11, 2'd2, 1'b1);
        step(2'b00, 2'd0, 1'b0);

        // Rebuild to 5 and reset mid-operation
        step(2'b11, 2'd0, 1'b0);
        step(2'b11, 2'd0, 1'b0);
        step(2'b01, 2'd0, 1'b0);
        apply_reset();
        step(2'b00, 2'd1, 1'b0);

        // Empty queue, pair push with pop_cnt=1
        step(2'b11, 2'd1, 1'b0);
        step(2'b00, 2'd3, 1'b0);
        step(2'b10, 2'd0, 1'b0);
        step(2'b00, 2'd2, 1'b0);
        step(2'b00, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of entries (power of two, >= 4).
REQ-002 SHALL have parameter DATA_W, default 96, meaning the payload width per instruction (pc, instr, predicted dest).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discard all contents (redirect/exception).
REQ-006 SHALL have port push_valid  input  2  per-slot valid of the fetch pair, slot 0 older.
REQ-007 SHALL have port push_data  input  2*DATA_W  fetch pair payload, slot 0 in the low bits.
REQ-008 SHALL have port push_ready  output  1  queue accepts a full pair this cycle.
REQ-009 SHALL have port pop_valid  output  2  head entries present; bit1 implies bit0.
REQ-010 SHALL have port pop_data  output  2*DATA_W  head (low) and head+1 (high) payloads.
REQ-011 SHALL have port pop_cnt  input  2  number of entries decode consumes this cycle (0..2).
REQ-012 SHALL have port count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-013 SHALL implement a circular buffer with head/tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-014 SHALL drive push_ready = (DEPTH - count >= 2), from registered state only; no combinational path from pop_cnt or push_valid.
REQ-015 SHALL, when push_ready and push_valid != 0, write valid slots in order at tail, compacting (2'b10 writes slot 1 as a single entry at tail).
REQ-016 SHALL ignore push_valid entirely while push_ready is low (no write, no pointer move).
REQ-017 SHALL drive pop_valid[0] = (count >= 1), pop_valid[1] = (count >= 2).
REQ-018 SHALL advance head by min(pop_cnt, number of set pop_valid bits); excess pop_cnt is clamped, never underflows; pop_cnt = 3 treated as 2.
REQ-019 SHALL apply push and pop in the same cycle: count_next = count + pushed - popped.
REQ-020 SHALL, on flush, set head, tail and count to 0 next cycle, ignoring any simultaneous push and pop.
REQ-021 SHALL give pop_data undefined content for slots whose pop_valid bit is low; bench shall not check it.
REQ-022 SHALL keep entry storage non-reset; only pointers and count are reset.

Reset
REQ-023 SHALL, while reset is high at a clock edge, set head = 0, tail = 0, count = 0; reset takes priority over flush, push and pop.
REQ-024 SHALL present after reset: pop_valid = 2'b00, push_ready = 1, count = 0.
REQ-025 SHALL allow reset asserted mid-operation (queue partially full) to discard all entries identically to power-up reset.

Configuration
REQ-026 SHALL recognise macro INST_QUEUE_BYPASS_EN.
REQ-027 With INST_QUEUE_BYPASS_EN defined: when count = 0 and flush low, pushed slots appear on pop_valid/pop_data in the same cycle; entries consumed via pop_cnt that cycle are not stored; unconsumed ones are written.
REQ-028 Without INST_QUEUE_BYPASS_EN: push-to-pop latency is exactly 1 cycle; pop ports reflect stored entries only.
REQ-029 SHALL keep push_ready identical in both configurations.

Verification
REQ-030 Reset then push pair A,B (push_valid=2'b11), pop_cnt=0 -> next cycle count=2, pop_valid=2'b11, pop_data={B,A}.
REQ-031 Push pairs with pop_cnt=0 until full (DEPTH=8) -> push_ready drops at count=7 or 8; further pushes ignored; count stays 8 when four pairs pushed.
REQ-032 Count=1, push_valid=2'b11, pop_cnt=2 -> one entry popped (clamped), two written, count=2 next cycle.
REQ-033 Push/pop 2 per cycle for 20 cycles -> tail/head wrap past 7 to 0; data emerges in push order, count constant.
REQ-034 Count=5, flush and push_valid=2'b11 same cycle -> count=0, pop_valid=2'b00 next cycle; reset with count=5 -> same.
REQ-035 With INST_QUEUE_BYPASS_EN, empty queue, push_valid=2'b11, pop_cnt=1 -> pop_data[0] = slot 0 same cycle, count=1 next cycle holding slot 1; without macro -> pop_valid=2'b00 that cycle.
